cv32e40x_csr_bank: RTL and testbench

CV32E40X_CSR_BANK -- requirements
Module: cv32e40x_csr_bank

---
 rtl/cv32e40x_pkg.sv | 11 +
 rtl/cv32e40x_csr_entry.sv | 39 +++
 rtl/cv32e40x_csr_bank.sv | 172 +++++++++++++++++
 tb/tb_cv32e40x_csr_bank.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40x_pkg.sv
// Shared types for the CSR bank: the access operation encoding.
package cv32e40x_pkg;

  typedef enum logic [1:0] {
    CSR_OP_READ  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_e;

endpackage : cv32e40x_pkg

// File: rtl/cv32e40x_csr_entry.sv
// One CSR storage entry with an optional inverted shadow copy and a
// combinational integrity-mismatch flag.
module cv32e40x_csr_entry #(
  parameter int unsigned      WIDTH      = 32,
  parameter int               SHADOWCOPY = 1,
  parameter logic [WIDTH-1:0] RESETVALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] value_o,
  output logic             mismatch_o
);

  logic [WIDTH-1:0] r_value;
  logic [WIDTH-1:0] r_shadow;

  // The shadow always holds the bitwise complement of the live value.
  function automatic logic f_shadow_mismatch(input logic [WIDTH-1:0] value,
                                             input logic [WIDTH-1:0] shadow);
    return (value != ~shadow);
  endfunction

  // Load reset value / complement on reset, otherwise capture a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_value  <= RESETVALUE;
      r_shadow <= ~RESETVALUE;
    end else if (we_i) begin
      r_value  <= wdata_i;
      r_shadow <= ~wdata_i;
    end
  end

  assign value_o    = r_value;
  assign mismatch_o = (SHADOWCOPY != 0) ? f_shadow_mismatch(r_value, r_shadow) : 1'b0;

endmodule : cv32e40x_csr_entry

// File: rtl/cv32e40x_csr_bank.sv
// CSR bank: READ/WRITE/SET/CLEAR access with WARL masking, one-cycle
// response, background shadow scrubber and a sticky integrity alarm.
module cv32e40x_csr_bank
  import cv32e40x_pkg::*;
#(
  parameter int unsigned                     WIDTH       = 32,
  parameter int unsigned                     NUM_REGS    = 4,
  parameter int                              SHADOWCOPY  = 1,
  parameter logic [NUM_REGS*WIDTH-1:0]       RESETVALUES = '0,
  parameter logic [NUM_REGS*WIDTH-1:0]       WARL_MASK   = '1,
  localparam int                             AW          = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_i,
  input  logic [1:0]       op_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             rvalid_o,
  output logic [WIDTH-1:0] rdata_o,
  output logic             rerr_o,
  output logic             err_o,
  output logic [AW-1:0]    err_idx_o,
  input  logic             err_clr_i
);

  localparam logic [AW:0]   NUM_REGS_W = (AW+1)'(NUM_REGS);
  localparam logic [AW-1:0] LAST_IDX   = AW'(NUM_REGS - 1);

  logic [WIDTH-1:0]    w_values [NUM_REGS];
  logic [WIDTH-1:0]    w_mask   [NUM_REGS];
  logic [NUM_REGS-1:0] w_mismatch;
  logic [NUM_REGS-1:0] w_we;

  csr_op_e          w_op;
  logic             w_addr_ok;
  logic [WIDTH-1:0] w_old;
  logic             w_old_mm;
  logic [WIDTH-1:0] w_mask_sel;
  logic [WIDTH-1:0] w_next;
  logic             w_is_write;
  logic [WIDTH-1:0] w_merged;
  logic             w_read_mm;
  logic             w_scrub_mm;
  logic             w_err_event;
  logic [AW-1:0]    w_err_idx;

  logic             r_rvalid;
  logic [WIDTH-1:0] r_rdata;
  logic             r_rerr;
  logic             r_err;
  logic [AW-1:0]    r_err_idx;
  logic [AW-1:0]    r_scrub_ptr;

  assign w_op = csr_op_e'(op_i);

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_entry
    assign w_mask[g] = WARL_MASK[g*WIDTH +: WIDTH];
    assign w_we[g]   = req_i & ~rst & w_addr_ok & w_is_write & (addr_i == AW'(g));

    cv32e40x_csr_entry #(
      .WIDTH      (WIDTH),
      .SHADOWCOPY (SHADOWCOPY),
      .RESETVALUE (RESETVALUES[g*WIDTH +: WIDTH])
    ) u_entry (
      .clk        (clk),
      .rst        (rst),
      .we_i       (w_we[g]),
      .wdata_i    (w_merged),
      .value_o    (w_values[g]),
      .mismatch_o (w_mismatch[g])
    );
  end

  // Select the addressed entry, its mask and integrity flag; out-of-range reads as zero.
  always_comb begin
    w_addr_ok  = ({1'b0, addr_i} < NUM_REGS_W);
    w_old      = '0;
    w_old_mm   = 1'b0;
    w_mask_sel = '0;
    if (w_addr_ok) begin
      w_old      = w_values[addr_i];
      w_old_mm   = w_mismatch[addr_i];
      w_mask_sel = w_mask[addr_i];
    end else begin
      w_old      = '0;
      w_old_mm   = 1'b0;
      w_mask_sel = '0;
    end
  end

  // Decode the operation into the unmasked next value.
  always_comb begin
    w_next     = w_old;
    w_is_write = 1'b0;
    case (w_op)
      CSR_OP_READ: begin
        w_next     = w_old;
        w_is_write = 1'b0;
      end
      CSR_OP_WRITE: begin
        w_next     = wdata_i;
        w_is_write = 1'b1;
      end
      CSR_OP_SET: begin
        w_next     = w_old | wdata_i;
        w_is_write = 1'b1;
      end
      CSR_OP_CLEAR: begin
        w_next     = w_old & ~wdata_i;
        w_is_write = 1'b1;
      end
      default: begin
        w_next     = w_old;
        w_is_write = 1'b0;
      end
    endcase
  end

  // Non-writable bits keep their current (reset) value.
  assign w_merged = (w_next & w_mask_sel) | (w_old & ~w_mask_sel);

  // Integrity events: a READ hitting a bad entry, or the scrubber in an idle cycle.
  // The two are exclusive because scrubbing only happens when req_i is low.
  assign w_read_mm   = req_i & w_addr_ok & (w_op == CSR_OP_READ) & w_old_mm;
  assign w_scrub_mm  = ~req_i & w_mismatch[r_scrub_ptr];
  assign w_err_event = w_read_mm | w_scrub_mm;
  assign w_err_idx   = req_i ? addr_i : r_scrub_ptr;

  // One-cycle registered response carrying the pre-update value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rerr   <= 1'b0;
    end else begin
      r_rvalid <= req_i;
      r_rdata  <= req_i ? w_old : '0;
      r_rerr   <= req_i & (~w_addr_ok | w_read_mm);
    end
  end

  // Scrub pointer advances only in idle cycles, wrapping at the last entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scrub_ptr <= '0;
    end else if (!req_i) begin
      r_scrub_ptr <= (r_scrub_ptr == LAST_IDX) ? {AW{1'b0}} : r_scrub_ptr + AW'(1);
    end
  end

  // Sticky alarm keeps the first failing index; a new event beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err     <= 1'b0;
      r_err_idx <= '0;
    end else if (w_err_event && (!r_err || err_clr_i)) begin
      r_err     <= 1'b1;
      r_err_idx <= w_err_idx;
    end else if (err_clr_i) begin
      r_err     <= 1'b0;
      r_err_idx <= '0;
    end
  end

  assign rvalid_o  = r_rvalid;
  assign rdata_o   = r_rdata;
  assign rerr_o    = r_rerr;
  assign err_o     = r_err;
  assign err_idx_o = r_err_idx;

endmodule : cv32e40x_csr_bank

// File: tb/tb_cv32e40x_csr_bank.sv
// Scoreboard bench for cv32e40x_csr_bank (3 entries, 32-bit, shadow on).
module tb_cv32e40x_csr_bank;

  localparam int NR = 3;
  localparam logic [NR*32-1:0] RV = {32'h0BAD_C0DE, 32'h0000_00A5, 32'h0000_00F0};
  localparam logic [NR*32-1:0] WM = {32'h00FF_FFFF, 32'hFFFF_FFFF, 32'h0000_000F};

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i;
  logic [1:0]  op_i;
  logic [1:0]  addr_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        rerr_o;
  logic        err_o;
  logic [1:0]  err_idx_o;
  logic        err_clr_i;

  cv32e40x_csr_bank #(
    .WIDTH(32), .NUM_REGS(NR), .SHADOWCOPY(1), .RESETVALUES(RV), .WARL_MASK(WM)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .op_i(op_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .rerr_o(rerr_o),
    .err_o(err_o), .err_idx_o(err_idx_o), .err_clr_i(err_clr_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          stamp;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] mdl [NR];
  bit          corrupt [NR];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rv_of(input int i);
    logic [NR*32-1:0] v;
    v = RV;
    return v[i*32 +: 32];
  endfunction

  function automatic logic [31:0] wm_of(input int i);
    logic [NR*32-1:0] v;
    v = WM;
    return v[i*32 +: 32];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      mdl[i]     = rv_of(i);
      corrupt[i] = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one access, record its expected response, apply it to the model.
  task automatic issue(input logic [1:0] op, input logic [1:0] addr,
                       input logic [31:0] wd, input logic clr);
    exp_t        e;
    logic [31:0] nxt;
    e.stamp = cyc;
    if (addr >= 2'(NR)) begin
      e.data = 32'h0;
      e.err  = 1'b1;
    end else begin
      e.data = mdl[addr];
      e.err  = (op == 2'b00) && corrupt[addr];
      nxt = mdl[addr];
      case (op)
        2'b01:   nxt = wd;
        2'b10:   nxt = mdl[addr] | wd;
        2'b11:   nxt = mdl[addr] & ~wd;
        default: nxt = mdl[addr];
      endcase
      if (op != 2'b00) begin
        mdl[addr]     = (nxt & wm_of(int'(addr))) | (mdl[addr] & ~wm_of(int'(addr)));
        corrupt[addr] = 1'b0;
      end
    end
    q.push_back(e);
    req_i     = 1'b1;
    op_i      = op;
    addr_i    = addr;
    wdata_i   = wd;
    err_clr_i = clr;
    @(posedge clk);
    #1;
    req_i     = 1'b0;
    err_clr_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: match every response against the oldest expectation.
  always @(negedge clk) begin
    if (rvalid_o) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: got rvalid=1 expected no response (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("resp_latency", 32'(cyc), 32'(e.stamp + 1));
        chk("resp_rdata", rdata_o, e.data);
        chk("resp_rerr", {31'h0, rerr_o}, {31'h0, e.err});
      end
    end else if (q.size() > 0 && q[0].stamp + 1 <= cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_rvalid: got rvalid=0 expected response for cycle %0d", q[0].stamp);
      void'(q.pop_front());
    end
  end

  initial begin
    bit seen;
    rst = 1'b1; req_i = 1'b0; op_i = 2'b00; addr_i = 2'b00;
    wdata_i = 32'h0; err_clr_i = 1'b0;
    model_reset();
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_rvalid", {31'h0, rvalid_o}, 32'h0);
    chk("reset_rdata", rdata_o, 32'h0);
    chk("reset_rerr", {31'h0, rerr_o}, 32'h0);
    chk("reset_err", {31'h0, err_o}, 32'h0);
    chk("reset_err_idx", {30'h0, err_idx_o}, 32'h0);
    @(posedge clk);
    #1;

    // Randomized traffic with idle gaps (scrubber runs on clean entries).
    for (int i = 0; i < 300; i++) begin
      issue(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom,
            1'($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(2);
    @(negedge clk);
    chk("random_no_alarm", {31'h0, err_o}, 32'h0);
    @(posedge clk);
    #1;

    // Request during reset is dropped; entries return to reset values.
    rst = 1'b1; req_i = 1'b1; op_i = 2'b01; addr_i = 2'd1; wdata_i = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    rst = 1'b0; req_i = 1'b0;
    model_reset();
    idle(2);

    // Reset value readback.
    issue(2'b00, 2'd1, 32'h0, 1'b0);
    // WARL: SET then CLEAR on entry 0 (mask 0x0F).
    issue(2'b10, 2'd0, 32'h0000_000F, 1'b0);
    issue(2'b11, 2'd0, 32'h0000_00FF, 1'b0);
    issue(2'b00, 2'd0, 32'h0, 1'b0);
    // Out-of-range write, then all entries unchanged.
    issue(2'b01, 2'd3, 32'hFFFF_FFFF, 1'b0);
    for (int a = 0; a < NR; a++) issue(2'b00, 2'(a), 32'h0, 1'b0);
    // Back-to-back write then read.
    issue(2'b01, 2'd1, 32'h0000_1234, 1'b0);
    issue(2'b00, 2'd1, 32'h0, 1'b0);
    idle(2);

    // Corrupt entry 2 shadow; scrubber must flag it.
    force dut.g_entry[2].u_entry.r_shadow = 32'h0000_0000;
    corrupt[2] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      @(negedge clk);
      if (err_o) seen = 1'b1;
    end
    chk("scrub_err", {31'h0, err_o}, 32'h1);
    chk("scrub_err_idx", {30'h0, err_idx_o}, 32'h2);
    @(posedge clk);
    #1;
    idle(3);
    @(negedge clk);
    chk("err_idx_sticky", {30'h0, err_idx_o}, 32'h2);
    @(posedge clk);
    #1;

    // Repair entry 2 by writing it.
    release dut.g_entry[2].u_entry.r_shadow;
    issue(2'b01, 2'd2, 32'h00AA_0000, 1'b0);

    // New mismatch on entry 1 in the same cycle as a clear: the mismatch wins.
    force dut.g_entry[1].u_entry.r_shadow = 32'h0000_0000;
    corrupt[1] = 1'b1;
    issue(2'b00, 2'd1, 32'h0, 1'b1);
    @(negedge clk);
    chk("clr_vs_mismatch_err", {31'h0, err_o}, 32'h1);
    chk("clr_vs_mismatch_idx", {30'h0, err_idx_o}, 32'h1);
    @(posedge clk);
    #1;

    // Repair entry 1 and clear the alarm.
    release dut.g_entry[1].u_entry.r_shadow;
    issue(2'b01, 2'd1, 32'h0000_1234, 1'b0);
    issue(2'b00, 2'd0, 32'h0, 1'b1);
    idle(4);
    @(negedge clk);
    chk("cleared_err", {31'h0, err_o}, 32'h0);
    chk("cleared_err_idx", {30'h0, err_idx_o}, 32'h0);
    for (int a = 0; a < NR; a++) issue(2'b00, 2'(a), 32'h0, 1'b0);
    idle(3);
    chk("queue_drained", 32'(q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_cv32e40x_csr_bank
